// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order memory request tracking,
// and a small {pc, instr, fault} buffer feeding decode. Redirects flush everything.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_v_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_v_i,
    input  logic [31:0]     imem_rsp_instr_i,
    input  logic            imem_rsp_err_i,
    input  logic            flush_v_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            dec_v_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_instr_o,
    output logic [XLEN-1:0] dec_pc_o,
    output logic            dec_fault_o
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam int              CNT_W     = PTR_W + 1;
    localparam int              DROP_W    = CNT_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    logic [XLEN-1:0]   pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [DROP_W-1:0] drop;

    logic [XLEN-1:0]   pcq_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  pcq_wr;
    logic [PTR_W-1:0]  pcq_rd;

    logic [XLEN-1:0]   fq_pc    [FIFO_DEPTH];
    logic [31:0]       fq_instr [FIFO_DEPTH];
    logic              fq_fault [FIFO_DEPTH];
    logic [PTR_W-1:0]  fq_wr;
    logic [PTR_W-1:0]  fq_rd;

    logic [CNT_W:0]    credit_used;
    logic              req_v;
    logic              accept;
    logic              rsp_take;
    logic              rsp_drop;
    logic              pop;
    logic [DROP_W-1:0] outstanding;
    logic [DROP_W-1:0] flush_drop;

    // Credit uses registered counts only, so a request never disappears without acceptance.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign req_v       = reset_n & ~flush_v_i & (credit_used < DEPTH_C);
    assign accept      = req_v & imem_req_ready_i;
    assign rsp_take    = imem_rsp_v_i & (drop == '0);
    assign rsp_drop    = imem_rsp_v_i & (drop != '0);
    assign pop         = dec_v_o & dec_ready_i;

    // Stale responses still owed by memory on a redirect, including ones left from an earlier redirect.
    assign outstanding = drop + DROP_W'(inflight);
    assign flush_drop  = (imem_rsp_v_i && outstanding != '0) ? outstanding - DROP_W'(1) : outstanding;

    assign imem_req_v_o    = req_v;
    assign imem_req_addr_o = pc;
    assign dec_v_o         = (fifo_cnt != '0);
    assign dec_pc_o        = fq_pc[fq_rd];
    assign dec_instr_o     = XLEN'(fq_instr[fq_rd]);
    assign dec_fault_o     = fq_fault[fq_rd];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_VECTOR;
            inflight <= '0;
            fifo_cnt <= '0;
            drop     <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            fq_wr    <= '0;
            fq_rd    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pcq_mem[i]  <= '0;
                fq_pc[i]    <= '0;
                fq_instr[i] <= '0;
                fq_fault[i] <= 1'b0;
            end
        end else if (flush_v_i) begin
            pc       <= flush_pc_i & ~XLEN'(3);
            inflight <= '0;
            fifo_cnt <= '0;
            drop     <= flush_drop;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            fq_wr    <= '0;
            fq_rd    <= '0;
        end else begin
            if (accept) begin
                pc              <= pc + XLEN'(4);
                pcq_mem[pcq_wr] <= pc;
                pcq_wr          <= pcq_wr + PTR_W'(1);
            end
            if (rsp_take) begin
                pcq_rd          <= pcq_rd + PTR_W'(1);
                fq_pc[fq_wr]    <= pcq_mem[pcq_rd];
                fq_instr[fq_wr] <= imem_rsp_err_i ? NOP_INSTR : imem_rsp_instr_i;
                fq_fault[fq_wr] <= imem_rsp_err_i;
                fq_wr           <= fq_wr + PTR_W'(1);
            end
            if (rsp_drop) begin
                drop <= drop - DROP_W'(1);
            end
            if (pop) begin
                fq_rd <= fq_rd + PTR_W'(1);
            end
            inflight <= inflight + CNT_W'(accept) - CNT_W'(rsp_take);
            fifo_cnt <= fifo_cnt + CNT_W'(rsp_take) - CNT_W'(pop);
        end
    end

    // A response with nothing outstanding means the memory broke ordering.
    rsp_without_request : assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rsp_v_i && inflight == '0 && drop == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memory with configurable latency,
// accept/pop monitors, and hand-computed expected PCs/instructions per scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_v_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b0;
    logic        imem_rsp_v_i = 1'b0;
    logic [31:0] imem_rsp_instr_i = '0;
    logic        imem_rsp_err_i = 1'b0;
    logic        flush_v_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        dec_v_o;
    logic        dec_ready_i = 1'b0;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_fault_o;

    int          cyc = 0;
    int          lat = 1;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] acc_addr  [$];
    int          acc_cyc   [$];
    logic [31:0] obs_pc    [$];
    logic [31:0] obs_instr [$];
    logic        obs_fault [$];
    int          obs_cyc   [$];

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_req_v_o     (imem_req_v_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_v_i     (imem_rsp_v_i),
        .imem_rsp_instr_i (imem_rsp_instr_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .flush_v_i        (flush_v_i),
        .flush_pc_i       (flush_pc_i),
        .dec_v_o          (dec_v_o),
        .dec_ready_i      (dec_ready_i),
        .dec_instr_o      (dec_instr_o),
        .dec_pc_o         (dec_pc_o),
        .dec_fault_o      (dec_fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    // Memory model and monitors sample pre-edge values at the rising edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (imem_rsp_v_i) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (imem_req_v_o && imem_req_ready_i) begin
                pend_addr.push_back(imem_req_addr_o);
                pend_due.push_back(cyc + lat);
                acc_addr.push_back(imem_req_addr_o);
                acc_cyc.push_back(cyc);
            end
            if (dec_v_o && dec_ready_i && !flush_v_i) begin
                obs_pc.push_back(dec_pc_o);
                obs_instr.push_back(dec_instr_o);
                obs_fault.push_back(dec_fault_o);
                obs_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (reset_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_v_i     = 1'b1;
            imem_rsp_instr_i = instr_of(pend_addr[0]);
            imem_rsp_err_i   = (pend_addr[0] == err_addr);
        end else begin
            imem_rsp_v_i     = 1'b0;
            imem_rsp_instr_i = '0;
            imem_rsp_err_i   = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        acc_addr.delete();
        acc_cyc.delete();
        obs_pc.delete();
        obs_instr.delete();
        obs_fault.delete();
        obs_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        flush_v_i        = 1'b0;
        flush_pc_i       = '0;
        imem_req_ready_i = 1'b0;
        dec_ready_i      = 1'b0;
        err_addr         = 32'hFFFF_FFF0;
        tick(2);
        clear_logs();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(1);
        check_eq("rst_req_v", imem_req_v_o, 0);
        check_eq("rst_dec_v", dec_v_o, 0);
        check_eq("rst_dec_pc", dec_pc_o, 0);
        check_eq("rst_dec_instr", dec_instr_o, 0);
        check_eq("rst_dec_fault", dec_fault_o, 0);
        check_eq("rst_req_addr", imem_req_addr_o, 0);

        // 1: streaming fetch, 1-cycle memory
        do_reset();
        lat = 1; imem_req_ready_i = 1'b1; dec_ready_i = 1'b1;
        tick(8);
        check_eq("t1_acc0", acc_addr[0], 32'h0);
        check_eq("t1_acc1", acc_addr[1], 32'h4);
        check_eq("t1_acc2", acc_addr[2], 32'h8);
        check_eq("t1_pc0", obs_pc[0], 32'h0);
        check_eq("t1_pc1", obs_pc[1], 32'h4);
        check_eq("t1_pc2", obs_pc[2], 32'h8);
        check_eq("t1_instr1", obs_instr[1], instr_of(32'h4));
        check_eq("t1_latency", obs_cyc[0] - acc_cyc[0], 2);

        // 2: decoder stalled fills the buffer, then drains in order
        do_reset();
        lat = 1; imem_req_ready_i = 1'b1; dec_ready_i = 1'b0;
        tick(20);
        check_eq("t2_acc_cnt", acc_addr.size(), 4);
        check_eq("t2_req_v_full", imem_req_v_o, 0);
        check_eq("t2_dec_v_full", dec_v_o, 1);
        check_eq("t2_head_pc", dec_pc_o, 32'h0);
        dec_ready_i = 1'b1;
        tick(10);
        check_eq("t2_pc0", obs_pc[0], 32'h0);
        check_eq("t2_pc1", obs_pc[1], 32'h4);
        check_eq("t2_pc2", obs_pc[2], 32'h8);
        check_eq("t2_pc3", obs_pc[3], 32'hC);
        check_eq("t2_resume", acc_addr[4], 32'h10);

        // 3: flush with two requests in flight on a 3-cycle memory
        do_reset();
        lat = 3; imem_req_ready_i = 1'b1; dec_ready_i = 1'b1;
        tick(2);
        imem_req_ready_i = 1'b0;
        check_eq("t3_inflight2", acc_addr.size(), 2);
        flush_v_i = 1'b1; flush_pc_i = 32'h200; imem_req_ready_i = 1'b1;
        #1;
        check_eq("t3_req_v_flush", imem_req_v_o, 0);
        tick(1);
        flush_v_i = 1'b0;
        tick(15);
        check_eq("t3_first_pc", obs_pc[0], 32'h200);
        check_eq("t3_first_instr", obs_instr[0], instr_of(32'h200));
        check_eq("t3_next_pc", obs_pc[1], 32'h204);
        check_eq("t3_acc_after", acc_addr[2], 32'h200);
        clear_logs();
        flush_v_i = 1'b1; flush_pc_i = 32'h203;
        tick(1);
        flush_v_i = 1'b0;
        tick(10);
        check_eq("t3_unaligned_acc", acc_addr[0], 32'h200);
        check_eq("t3_unaligned_pc", obs_pc[0], 32'h200);

        // 4: access fault becomes a NOP with fault set
        do_reset();
        lat = 1; imem_req_ready_i = 1'b1; dec_ready_i = 1'b1; err_addr = 32'h8;
        tick(10);
        check_eq("t4_ok_fault", obs_fault[1], 0);
        check_eq("t4_err_pc", obs_pc[2], 32'h8);
        check_eq("t4_err_instr", obs_instr[2], 32'h13);
        check_eq("t4_err_fault", obs_fault[2], 1);
        check_eq("t4_next_pc", obs_pc[3], 32'hC);
        check_eq("t4_next_fault", obs_fault[3], 0);
        check_eq("t4_next_instr", obs_instr[3], instr_of(32'hC));

        // 5: flush coincides with a response and a pop
        do_reset();
        lat = 1; imem_req_ready_i = 1'b1; dec_ready_i = 1'b1;
        tick(6);
        check_eq("t5_pre_rsp", imem_rsp_v_i, 1);
        check_eq("t5_pre_dec_v", dec_v_o, 1);
        clear_logs();
        flush_v_i = 1'b1; flush_pc_i = 32'h400;
        tick(1);
        flush_v_i = 1'b0;
        check_eq("t5_dec_v_after", dec_v_o, 0);
        tick(6);
        check_eq("t5_first_pc", obs_pc[0], 32'h400);
        check_eq("t5_second_pc", obs_pc[1], 32'h404);

        // 6: asynchronous reset with the buffer 3/4 full
        do_reset();
        lat = 1; imem_req_ready_i = 1'b1; dec_ready_i = 1'b0;
        for (int i = 0; i < 20 && acc_addr.size() < 3; i++) tick(1);
        imem_req_ready_i = 1'b0;
        check_eq("t6_acc3", acc_addr.size(), 3);
        tick(3);
        check_eq("t6_pre_dec_v", dec_v_o, 1);
        check_eq("t6_pre_head_instr", dec_instr_o, instr_of(32'h0));
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_req_v", imem_req_v_o, 0);
        check_eq("t6_rst_dec_v", dec_v_o, 0);
        check_eq("t6_rst_dec_pc", dec_pc_o, 0);
        check_eq("t6_rst_dec_instr", dec_instr_o, 0);
        check_eq("t6_rst_dec_fault", dec_fault_o, 0);
        tick(2);
        clear_logs();
        imem_req_ready_i = 1'b1;
        reset_n = 1'b1;
        tick(4);
        check_eq("t6_first_addr", acc_addr[0], 32'h0);
        check_eq("t6_second_addr", acc_addr[1], 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
